// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the control FSM and the instruction/data ports.
interface multicycle_ctrl_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  // Controller side: issues requests, receives acks.
  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack
  );

  // Memory side: receives requests, returns acks.
  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB],
// with sticky illegal-instruction and memory-timeout traps.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  multicycle_ctrl_if.master        mem,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic                     branch_taken,
  output logic                     ir_we,
  output logic                     pc_we,
  output logic [1:0]               pc_sel,
  output logic                     alu_a_sel,
  output logic                     alu_b_sel,
  output logic [3:0]               alu_ctrl,
  output logic [2:0]               imm_sel,
  output logic                     rf_we,
  output logic [1:0]               wb_sel,
  output logic                     retire,
  output logic                     illegal,
  output logic                     bus_err,
  output logic [2:0]               state_o
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  // Instruction class from the decoder fields (stable for the whole instruction).
  logic is_r, is_i, is_ld, is_st, is_br, is_lui, is_auipc, is_jal, is_jalr;
  logic f7_ok, is_shift, illegal_instr;
  logic waiting, ack_c, timeout_hit;

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LOAD);
  assign is_st    = (opcode == OP_STORE);
  assign is_br    = (opcode == OP_BRANCH);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);

  // funct7 must be all-zero, or the alternate encoding on ADD/SUB or SRL/SRA only.
  assign f7_ok    = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
  assign is_shift = is_i && ((funct3 == 3'b001) || (funct3 == 3'b101));
  assign illegal_instr = !(is_r || is_i || is_ld || is_st || is_br ||
                           is_lui || is_auipc || is_jal || is_jalr) ||
                         (is_r && !f7_ok) || (is_shift && !f7_ok);

  // Memory wait bookkeeping shared by FETCH and MEM.
  assign waiting     = (state_q == S_FETCH) || (state_q == S_MEM);
  assign ack_c       = (state_q == S_FETCH) ? mem.imem_ack : mem.dmem_ack;
  assign timeout_hit = TIMEOUT_EN && waiting && !ack_c && (cnt_q == CNT_LAST);

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = 4'd2;
      3'b010:  op = 4'd3;
      3'b011:  op = 4'd4;
      3'b100:  op = 4'd5;
      3'b101:  op = alt ? 4'd7 : 4'd6;
      3'b110:  op = 4'd8;
      default: op = 4'd9;
    endcase
    return op;
  endfunction

  // State register, wait counter and sticky trap flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state, counter and trap-flag logic.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_FETCH: begin
        if (mem.imem_ack) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (illegal_instr) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_br)                state_d = S_FETCH;
        else if (is_ld || is_st)  state_d = S_MEM;
        else                      state_d = S_WB;
      end
      S_MEM: begin
        if (mem.dmem_ack) begin
          state_d = is_st ? S_FETCH : S_WB;
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_TRAP;
    endcase

    // Counter restarts on every state change, so it is zero on entering FETCH/MEM.
    cnt_d = cnt_q;
    if (state_d != state_q)                   cnt_d = '0;
    else if (TIMEOUT_EN && waiting && !ack_c) cnt_d = cnt_q + CNT_W'(1);
  end

  // Control outputs decoded from the current state; everything forced low during reset.
  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    alu_ctrl     = ALU_ADD;
    imm_sel      = 3'd0;
    rf_we        = 1'b0;
    wb_sel       = 2'b00;
    retire       = 1'b0;
    illegal      = 1'b0;
    bus_err      = 1'b0;
    state_o      = 3'd0;
    if (!rst) begin
      illegal = illegal_q;
      bus_err = bus_err_q;
      state_o = state_q;
      case (state_q)
        S_FETCH: begin
          mem.imem_req = 1'b1;
          ir_we        = mem.imem_ack;
        end
        S_EXEC: begin
          if (is_r)        alu_ctrl = alu_op(funct3, funct7[5]);
          else if (is_i)   alu_ctrl = alu_op(funct3, funct7[5] && (funct3 == 3'b101));
          else if (is_br)  alu_ctrl = ALU_SUB;
          else if (is_lui) alu_ctrl = ALU_PASS_B;
          else             alu_ctrl = ALU_ADD;
          alu_b_sel = !(is_r || is_br);
          alu_a_sel = is_auipc;
          if (is_st)                 imm_sel = 3'd1;
          else if (is_br)            imm_sel = 3'd2;
          else if (is_lui || is_auipc) imm_sel = 3'd3;
          else if (is_jal)           imm_sel = 3'd4;
          else                       imm_sel = 3'd0;
          if (is_br) begin
            pc_we  = 1'b1;
            pc_sel = branch_taken ? 2'b01 : 2'b00;
            retire = 1'b1;
          end
        end
        S_MEM: begin
          mem.dmem_req = 1'b1;
          mem.dmem_we  = is_st;
          if (mem.dmem_ack && is_st) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end
        end
        S_WB: begin
          rf_we  = 1'b1;
          pc_we  = 1'b1;
          retire = 1'b1;
          if (is_ld)                 wb_sel = 2'b01;
          else if (is_jal || is_jalr) wb_sel = 2'b10;
          if (is_jal)                pc_sel = 2'b01;
          else if (is_jalr)          pc_sel = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instructions, traps, reset and random mix.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       branch_taken;

  multicycle_ctrl_if m_if ();
  multicycle_ctrl_if t_if ();

  logic       ir_we, pc_we, alu_a_sel, alu_b_sel, rf_we, retire, illegal, bus_err;
  logic [1:0] pc_sel, wb_sel;
  logic [3:0] alu_ctrl;
  logic [2:0] imm_sel, state_o;

  logic       t_ir_we, t_pc_we, t_alu_a_sel, t_alu_b_sel, t_rf_we, t_retire, t_illegal, t_bus_err;
  logic [1:0] t_pc_sel, t_wb_sel;
  logic [3:0] t_alu_ctrl;
  logic [2:0] t_imm_sel, t_state_o;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .mem(m_if.master),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .branch_taken(branch_taken),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_ctrl(alu_ctrl), .imm_sel(imm_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .retire(retire), .illegal(illegal), .bus_err(bus_err),
    .state_o(state_o)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut_t (
    .clk(clk), .rst(rst), .mem(t_if.master),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .branch_taken(branch_taken),
    .ir_we(t_ir_we), .pc_we(t_pc_we), .pc_sel(t_pc_sel), .alu_a_sel(t_alu_a_sel),
    .alu_b_sel(t_alu_b_sel), .alu_ctrl(t_alu_ctrl), .imm_sel(t_imm_sel), .rf_we(t_rf_we),
    .wb_sel(t_wb_sel), .retire(t_retire), .illegal(t_illegal), .bus_err(t_bus_err),
    .state_o(t_state_o)
  );

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  logic [6:0] legal_ops [9];
  initial legal_ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};

  // Snapshot of every main-DUT output:
  // state, ireq, dreq, dwe, irwe, pcwe, pcsel, asel, bsel, alu, imm, rfwe, wbsel, retire, illegal, bus_err
  function automatic logic [24:0] obs();
    return {state_o, m_if.imem_req, m_if.dmem_req, m_if.dmem_we, ir_we, pc_we, pc_sel,
            alu_a_sel, alu_b_sel, alu_ctrl, imm_sel, rf_we, wb_sel, retire, illegal, bus_err};
  endfunction

  // Reference legality rules.
  function automatic bit model_illegal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bit known, f7_good;
    known = 1'b0;
    for (int i = 0; i < 9; i++) if (legal_ops[i] == op) known = 1'b1;
    if (!known) return 1'b1;
    f7_good = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    if (op == OP_R) return !f7_good;
    if (op == OP_I && (f3 == 3'd1 || f3 == 3'd5)) return !f7_good;
    return 1'b0;
  endfunction

  // Reference ALU operation selection.
  function automatic logic [3:0] model_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    logic [3:0] lut [8];
    lut = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (op == OP_R) return lut[f3] + ((f7[5] && (f3 == 3'd0 || f3 == 3'd5)) ? 4'd1 : 4'd0);
    if (op == OP_I) return lut[f3] + ((f7[5] && f3 == 3'd5) ? 4'd1 : 4'd0);
    if (op == OP_BR) return 4'd1;
    if (op == OP_LUI) return 4'd10;
    return 4'd0;
  endfunction

  function automatic logic [2:0] model_imm(input logic [6:0] op);
    case (op)
      OP_ST:              return 3'd1;
      OP_BR:              return 3'd2;
      OP_LUI, OP_AUIPC:   return 3'd3;
      OP_JAL:             return 3'd4;
      default:            return 3'd0;
    endcase
  endfunction

  // Assert rst for one edge, check forced-zero outputs, release and check FETCH.
  task automatic apply_reset();
    rst = 1'b1;
    m_if.imem_ack = 1'b0; m_if.dmem_ack = 1'b0;
    #1;
    checks++;
    if (obs() !== 25'd0) begin
      errors++; $display("FAIL rst_forced_low got=%h exp=0", obs());
    end
    @(negedge clk);
    #1;
    checks++;
    if (obs() !== 25'd0) begin
      errors++; $display("FAIL rst_held got=%h exp=0", obs());
    end
    rst = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd0 || m_if.imem_req !== 1'b1 || illegal !== 1'b0 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_release state=%0d ireq=%b ill=%b berr=%b exp state=0 ireq=1 ill=0 berr=0",
               state_o, m_if.imem_req, illegal, bus_err);
    end
  endtask

  // Run one instruction on the main DUT with given fetch/mem wait counts, checking every cycle.
  // Starts and ends just after a falling edge with the DUT in FETCH. abort_k >= 0 stops early.
  task automatic run_instr(input logic [31:0] word, input bit taken, input int wf, input int wm,
                           input int abort_k, input string name);
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    bit ill, ld, st, br, has_mem, has_wb, c_alu, c_imm;
    int n, retires, k_dec, k_ex, k_mem, k_wb;
    logic [2:0] e_state, e_imm;
    logic e_ireq, e_dreq, e_dwe, e_irwe, e_pcwe, e_asel, e_bsel, e_rfwe, e_ret, e_ill;
    logic [1:0] e_pcsel, e_wbsel;
    logic [3:0] e_alu;
    logic [24:0] exp_v, msk, got;

    op = word[6:0]; f3 = word[14:12]; f7 = word[31:25];
    ill = model_illegal(op, f3, f7);
    ld = (op == OP_LD); st = (op == OP_ST); br = (op == OP_BR);
    has_mem = !ill && (ld || st);
    has_wb  = !ill && !br && !st;
    k_dec = wf + 1; k_ex = wf + 2; k_mem = wf + 3;
    k_wb  = has_mem ? k_mem + wm + 1 : k_ex + 1;
    n = ill ? k_dec + 4 : (has_wb ? k_wb + 1 : (has_mem ? k_mem + wm + 1 : k_ex + 1));
    opcode = op; funct3 = f3; funct7 = f7; branch_taken = taken;
    retires = 0;

    for (int k = 0; k < n; k++) begin
      if (k == abort_k) return;
      e_state = 3'd0; e_ireq = 0; e_dreq = 0; e_dwe = 0; e_irwe = 0; e_pcwe = 0; e_pcsel = 2'd0;
      e_asel = 0; e_bsel = 0; e_alu = 4'd0; e_imm = 3'd0; e_rfwe = 0; e_wbsel = 2'd0; e_ret = 0;
      e_ill = 0; c_alu = 0; c_imm = 0;
      m_if.imem_ack = 1'b0; m_if.dmem_ack = 1'b0;
      if (k <= wf) begin
        m_if.imem_ack = (k == wf);
        e_ireq = 1; e_irwe = (k == wf);
      end else if (k == k_dec) begin
        e_state = 3'd1;
      end else if (ill) begin
        e_state = 3'd7; e_ill = 1;
      end else if (k == k_ex) begin
        e_state = 3'd2; c_alu = 1; c_imm = (op != OP_R);
        e_alu = model_alu(op, f3, f7); e_imm = model_imm(op);
        e_asel = (op == OP_AUIPC); e_bsel = !(op == OP_R || br);
        if (br) begin e_pcwe = 1; e_pcsel = taken ? 2'd1 : 2'd0; e_ret = 1; end
      end else if (has_mem && k < k_wb) begin
        e_state = 3'd3; e_dreq = 1; e_dwe = st;
        m_if.dmem_ack = (k == k_mem + wm);
        if (st && k == k_mem + wm) begin e_pcwe = 1; e_pcsel = 2'd0; e_ret = 1; end
      end else begin
        e_state = 3'd4; e_rfwe = 1; e_pcwe = 1; e_ret = 1;
        e_wbsel = ld ? 2'd1 : ((op == OP_JAL || op == OP_JALR) ? 2'd2 : 2'd0);
        e_pcsel = (op == OP_JAL) ? 2'd1 : ((op == OP_JALR) ? 2'd2 : 2'd0);
      end
      exp_v = {e_state, e_ireq, e_dreq, e_dwe, e_irwe, e_pcwe, e_pcsel, e_asel, e_bsel,
               e_alu, e_imm, e_rfwe, e_wbsel, e_ret, e_ill, 1'b0};
      msk = {3'b111, 1'b1, 1'b1, e_dreq, 1'b1, 1'b1, {2{e_pcwe}}, {2{c_alu}}, {4{c_alu}},
             {3{c_imm}}, 1'b1, {2{e_rfwe}}, 3'b111};
      #1;
      got = obs();
      if (got[2] === 1'b1) retires++;
      checks++;
      if ((got & msk) !== (exp_v & msk)) begin
        errors++;
        $display("FAIL %s cyc%0d got=%h exp=%h mask=%h", name, k, got, exp_v, msk);
      end
      @(negedge clk);
    end
    m_if.imem_ack = 1'b0; m_if.dmem_ack = 1'b0;
    checks++;
    if (retires != (ill ? 0 : 1)) begin
      errors++; $display("FAIL %s_retire_count got=%0d exp=%0d", name, retires, ill ? 0 : 1);
    end
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_alu();
    run_instr(32'h006100b3, 1'b0, 0, 0, -1, "add");
    run_instr(32'h40a58533, 1'b0, 1, 0, -1, "sub");
    run_instr(32'h4055d593, 1'b0, 0, 0, -1, "srai");
    run_instr(32'h12345537, 1'b0, 0, 0, -1, "lui");
    run_instr(32'h00001517, 1'b0, 2, 0, -1, "auipc");
  endtask

  task automatic test_branch();
    run_instr(32'h00208663, 1'b1, 0, 0, -1, "beq_taken");
    run_instr(32'h00208663, 1'b0, 0, 0, -1, "beq_not_taken");
  endtask

  task automatic test_load_store();
    run_instr(32'h00012083, 1'b0, 0, 3, -1, "lw_wait3");
    run_instr(32'h00312023, 1'b0, 0, 0, -1, "sw");
    run_instr(32'h00312023, 1'b0, 2, 1, -1, "sw_wait");
  endtask

  task automatic test_jumps();
    run_instr(32'h020000ef, 1'b0, 0, 0, -1, "jal");
    run_instr(32'h000100e7, 1'b0, 0, 0, -1, "jalr");
  endtask

  task automatic test_illegal();
    run_instr(32'h0000007f, 1'b0, 0, 0, -1, "opcode_7f");
    apply_reset();
    run_instr(32'h020100b3, 1'b0, 0, 0, -1, "r_bad_f7");
    apply_reset();
    run_instr(32'h40111093, 1'b0, 0, 0, -1, "slli_alt_f7");
    apply_reset();
  endtask

  // MEM_TIMEOUT=4 instance: trap after four unacked request cycles, ack on the fourth accepted.
  task automatic test_timeout();
    apply_reset();
    t_if.imem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (t_state_o !== 3'd0 || t_if.imem_req !== 1'b1 || t_bus_err !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait cyc%0d state=%0d ireq=%b berr=%b exp 0/1/0",
                 k, t_state_o, t_if.imem_req, t_bus_err);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (t_state_o !== 3'd7 || t_bus_err !== 1'b1 || t_if.imem_req !== 1'b0 || t_retire !== 1'b0) begin
        errors++;
        $display("FAIL timeout_trap cyc%0d state=%0d berr=%b ireq=%b ret=%b exp 7/1/0/0",
                 k, t_state_o, t_bus_err, t_if.imem_req, t_retire);
      end
      @(negedge clk);
    end
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      t_if.imem_ack = (k == 3);
      #1;
      @(negedge clk);
    end
    t_if.imem_ack = 1'b0;
    #1;
    checks++;
    if (t_state_o !== 3'd1 || t_bus_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_edge_ack state=%0d berr=%b exp state=1 berr=0", t_state_o, t_bus_err);
    end
    apply_reset();
  endtask

  // Reset during the MEM phase of a store abandons it cleanly.
  task automatic test_reset_mid_store();
    run_instr(32'h00312023, 1'b0, 0, 3, 4, "sw_abort");
    rst = 1'b1;
    m_if.dmem_ack = 1'b0;
    #1;
    checks++;
    if (m_if.dmem_req !== 1'b0 || retire !== 1'b0 || pc_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_store_rst dreq=%b ret=%b pcwe=%b exp 0/0/0", m_if.dmem_req, retire, pc_we);
    end
    @(negedge clk);
    #1;
    checks++;
    if (m_if.dmem_req !== 1'b0 || retire !== 1'b0 || state_o !== 3'd0) begin
      errors++;
      $display("FAIL mid_store_held dreq=%b ret=%b state=%0d exp 0/0/0", m_if.dmem_req, retire, state_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd0 || m_if.imem_req !== 1'b1 || illegal !== 1'b0 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_store_restart state=%0d ireq=%b ill=%b berr=%b exp 0/1/0/0",
               state_o, m_if.imem_req, illegal, bus_err);
    end
    run_instr(32'h006100b3, 1'b0, 0, 0, -1, "add_after_abort");
  endtask

  // Random back-to-back instructions with random waits and occasional illegal encodings.
  task automatic test_random();
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [31:0] word;
    int sel;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      op  = (sel == 9) ? 7'($urandom_range(0, 127)) : legal_ops[sel];
      f3  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 8) f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      else                          f7 = 7'($urandom_range(0, 127));
      word = {f7, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), f3,
              5'($urandom_range(0, 31)), op};
      run_instr(word, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                -1, "random");
      if (model_illegal(op, f3, f7)) apply_reset();
    end
  endtask

  initial begin
    rst = 1'b1;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; branch_taken = 1'b0;
    m_if.imem_ack = 1'b0; m_if.dmem_ack = 1'b0;
    t_if.imem_ack = 1'b0; t_if.dmem_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_alu();
    test_branch();
    test_load_store();
    test_jumps();
    test_illegal();
    test_timeout();
    test_reset_mid_store();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
